// File: rtl/alu_issue_stage_pkg.sv
// Shared decode constants and ID/EX bundle for the ALU issue stage.
// The opcode and aluSel codes here are the same ones the ALU uses.
package alu_issue_stage_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_BR   = 4'b0010;
    localparam logic [3:0] ALU_JMP  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_LUI  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [XLEN-1:0] rs2_val;
        logic [3:0]      alu_sel;
        logic [2:0]      func3;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
    } id_ex_t;

    // SUB only exists for register-register; SRA/SRL share funct7[5]
    // in both R and I forms.
    function automatic logic [3:0] alu_op(
        input logic [2:0] f3,
        input logic       alt,
        input logic       is_r
    );
        logic [3:0] sel;
        sel = ALU_ADD;
        case (f3)
            3'b000:  sel = (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_issue_stage_imm_gen.sv
// Immediate extraction for the issue stage (I/S/U/J formats).
// Ports: inst in; imm_i, imm_s, imm_u, imm_j sign-extended/shifted out.
module alu_issue_stage_imm_gen
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] imm_j
);

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20],
                    inst[30:21], 1'b0};

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode, operand forwarding, load-use stall, ID/EX reg.
// Ports: id_* decode slot, rs*_data regfile, fwd_a/b bypass, flush; ex_* ALU bundle, id_stall.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     id_inst,
    input  logic [31:0]     id_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            fwd_a_we,
    input  logic [4:0]      fwd_a_rd,
    input  logic [XLEN-1:0] fwd_a_data,
    input  logic            fwd_b_we,
    input  logic [4:0]      fwd_b_rd,
    input  logic [XLEN-1:0] fwd_b_data,
    input  logic            flush,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_in1,
    output logic [XLEN-1:0] ex_in2,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [3:0]      ex_aluSel,
    output logic [2:0]      ex_func3,
    output logic [4:0]      ex_rd,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    logic [0:0] state;
    id_ex_t     ex_q;
    id_ex_t     dec;
    id_ex_t     nxt;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] f3;
    logic       alt;

    assign opcode = id_inst[6:0];
    assign rd     = id_inst[11:7];
    assign f3     = id_inst[14:12];
    assign rs1    = id_inst[19:15];
    assign rs2    = id_inst[24:20];
    assign alt    = id_inst[30];

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    alu_issue_stage_imm_gen u_imm (
        .inst  (id_inst),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    // Source A is the younger result, so it wins over B.
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    always_comb begin
        op_a = rs1_data;
        if (rs1 == 5'd0)
            op_a = '0;
        else if (fwd_a_we && fwd_a_rd == rs1)
            op_a = fwd_a_data;
        else if (fwd_b_we && fwd_b_rd == rs1)
            op_a = fwd_b_data;
    end

    always_comb begin
        op_b = rs2_data;
        if (rs2 == 5'd0)
            op_b = '0;
        else if (fwd_a_we && fwd_a_rd == rs2)
            op_b = fwd_a_data;
        else if (fwd_b_we && fwd_b_rd == rs2)
            op_b = fwd_b_data;
    end

    logic is_r;
    logic is_i;
    logic is_ld;
    logic is_st;
    logic is_br;
    logic is_jal;
    logic is_jalr;
    logic is_lui;
    logic is_auipc;

    assign is_r     = opcode == OP_R;
    assign is_i     = opcode == OP_I;
    assign is_ld    = opcode == OP_LOAD;
    assign is_st    = opcode == OP_STORE;
    assign is_br    = opcode == OP_BRANCH;
    assign is_jal   = opcode == OP_JAL;
    assign is_jalr  = opcode == OP_JALR;
    assign is_lui   = opcode == OP_LUI;
    assign is_auipc = opcode == OP_AUIPC;

    logic known;
    logic use_rs1;
    logic use_rs2;
    logic wr_op;

    always_comb begin
        dec         = '0;
        dec.in1     = op_a;
        dec.in2     = op_b;
        dec.rs2_val = op_b;
        dec.func3   = f3;
        dec.alu_sel = ALU_ADD;
        known       = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        wr_op       = 1'b0;
        unique case (1'b1)
            is_r: begin
                known       = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                wr_op       = 1'b1;
                dec.alu_sel = alu_op(f3, alt, 1'b1);
            end
            is_i: begin
                known       = 1'b1;
                use_rs1     = 1'b1;
                wr_op       = 1'b1;
                dec.alu_sel = alu_op(f3, alt, 1'b0);
                // shift amount only; drop funct7 from the immediate
                dec.in2 = (f3 == 3'b001 || f3 == 3'b101)
                        ? {27'b0, rs2} : imm_i;
            end
            is_ld: begin
                known       = 1'b1;
                use_rs1     = 1'b1;
                wr_op       = 1'b1;
                dec.memread = 1'b1;
                dec.in2     = imm_i;
            end
            is_st: begin
                known        = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                dec.memwrite = 1'b1;
                dec.in2      = imm_s;
            end
            is_br: begin
                known       = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                dec.alu_sel = ALU_BR;
            end
            is_jal: begin
                known       = 1'b1;
                wr_op       = 1'b1;
                dec.alu_sel = ALU_JMP;
                dec.in1     = id_pc;
                dec.in2     = imm_j;
            end
            is_jalr: begin
                known       = 1'b1;
                use_rs1     = 1'b1;
                wr_op       = 1'b1;
                dec.alu_sel = ALU_JMP;
                dec.in2     = imm_i;
            end
            is_lui: begin
                known       = 1'b1;
                wr_op       = 1'b1;
                dec.alu_sel = ALU_LUI;
                // ALU appends the low 12 zeros itself
                dec.in2     = {12'b0, id_inst[31:12]};
            end
            is_auipc: begin
                known   = 1'b1;
                wr_op   = 1'b1;
                dec.in1 = id_pc;
                dec.in2 = imm_u;
            end
            default: ;
        endcase
        dec.regwrite = wr_op && (rd != 5'd0);
        dec.rd       = dec.regwrite ? rd : 5'd0;
    end

    logic load_use;
    logic stall_c;
    logic issue;

    assign load_use = ex_q.valid && ex_q.memread && ex_q.rd != 5'd0
                   && ((use_rs1 && rs1 == ex_q.rd)
                    || (use_rs2 && rs2 == ex_q.rd));

    assign stall_c  = state == RUN && id_valid && load_use;
    assign id_stall = rst && !flush && stall_c;

    assign issue = id_valid && known && id_inst != NOP_INST
                && !stall_c && !flush;

    always_comb begin
        nxt       = dec;
        nxt.valid = issue;
        if (!issue) begin
            nxt.regwrite = 1'b0;
            nxt.memread  = 1'b0;
            nxt.memwrite = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            ex_q  <= '0;
        end else begin
            state <= (stall_c && !flush) ? STALL : RUN;
            ex_q  <= nxt;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_in1      = ex_q.in1;
    assign ex_in2      = ex_q.in2;
    assign ex_rs2_val  = ex_q.rs2_val;
    assign ex_aluSel   = ex_q.alu_sel;
    assign ex_func3    = ex_q.func3;
    assign ex_rd       = ex_q.rd;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions,
// expected ID/EX bundles queued at issue and checked by a monitor.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_inst = 32'h13;
    logic [31:0] id_pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        fwd_a_we = 1'b0;
    logic [4:0]  fwd_a_rd = '0;
    logic [31:0] fwd_a_data = '0;
    logic        fwd_b_we = 1'b0;
    logic [4:0]  fwd_b_rd = '0;
    logic [31:0] fwd_b_data = '0;
    logic        flush = 1'b0;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_in1;
    logic [31:0] ex_in2;
    logic [31:0] ex_rs2_val;
    logic [3:0]  ex_aluSel;
    logic [2:0]  ex_func3;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_a_we(fwd_a_we), .fwd_a_rd(fwd_a_rd),
        .fwd_a_data(fwd_a_data),
        .fwd_b_we(fwd_b_we), .fwd_b_rd(fwd_b_rd),
        .fwd_b_data(fwd_b_data),
        .flush(flush), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2),
        .ex_rs2_val(ex_rs2_val), .ex_aluSel(ex_aluSel),
        .ex_func3(ex_func3), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite)
    );

    typedef struct {
        string       tag;
        logic        v;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] rs2v;
        logic [3:0]  sel;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        cd;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(
        input string tag, input logic v,
        input logic [31:0] in1, input logic [31:0] in2,
        input logic [31:0] rs2v, input logic [3:0] sel,
        input logic [2:0] f3, input logic [4:0] rd,
        input logic rw, input logic mr, input logic mw,
        input logic cd);
        exp_t e;
        e.tag = tag; e.v = v; e.in1 = in1; e.in2 = in2;
        e.rs2v = rs2v; e.sel = sel; e.f3 = f3; e.rd = rd;
        e.rw = rw; e.mr = mr; e.mw = mw; e.cd = cd;
        return e;
    endfunction

    function automatic exp_t bub(input string tag);
        return mk(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // monitor: one expected bundle per clock after each issue
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, ".valid"}, 32'(ex_valid), 32'(e.v));
            chk({e.tag, ".regwrite"}, 32'(ex_regwrite), 32'(e.rw));
            chk({e.tag, ".memread"}, 32'(ex_memread), 32'(e.mr));
            chk({e.tag, ".memwrite"}, 32'(ex_memwrite), 32'(e.mw));
            if (e.cd) begin
                chk({e.tag, ".in1"}, ex_in1, e.in1);
                chk({e.tag, ".in2"}, ex_in2, e.in2);
                chk({e.tag, ".rs2v"}, ex_rs2_val, e.rs2v);
                chk({e.tag, ".sel"}, 32'(ex_aluSel), 32'(e.sel));
                chk({e.tag, ".f3"}, 32'(ex_func3), 32'(e.f3));
                chk({e.tag, ".rd"}, 32'(ex_rd), 32'(e.rd));
            end
        end
    end

    task automatic issue(
        input logic [31:0] inst, input logic v,
        input logic [31:0] a, input logic [31:0] b,
        input logic faw, input logic [4:0] far,
        input logic [31:0] fad,
        input logic fbw, input logic [4:0] fbr,
        input logic [31:0] fbd,
        input logic fl, input logic rs,
        input logic stl, input exp_t e);
        @(negedge clk);
        id_inst = inst; id_valid = v;
        rs1_data = a; rs2_data = b;
        fwd_a_we = faw; fwd_a_rd = far; fwd_a_data = fad;
        fwd_b_we = fbw; fwd_b_rd = fbr; fwd_b_data = fbd;
        flush = fl; rst = rs;
        #1;
        chk({e.tag, ".stall"}, 32'(id_stall), 32'(stl));
        q.push_back(e);
    endtask

    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] SUB  = 32'h402081B3;
    localparam logic [31:0] ADD0 = 32'h002001B3;
    localparam logic [31:0] LUI  = 32'hABCDE237;
    localparam logic [31:0] SRAI = 32'h4030D093;
    localparam logic [31:0] ADDI = 32'hFFF08393;
    localparam logic [31:0] SW   = 32'h0020A423;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] AUI  = 32'h12345497;
    localparam logic [31:0] ADDX = 32'h00208033;
    localparam logic [31:0] AND_ = 32'h0020F1B3;
    localparam logic [31:0] LW   = 32'h0000A283;
    localparam logic [31:0] ADD6 = 32'h00528333;

    localparam logic [31:0] A = 32'h80000010;
    localparam logic [31:0] B = 32'h00000007;

    initial begin
        issue(ADD, 1, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0,
              mk("rst0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        issue(ADD, 1, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0,
              mk("rst1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        issue(ADD, 1, 5, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              mk("add", 1, 5, 7, 7, 4'b0000, 0, 3, 1, 0, 0, 1));
        issue(SUB, 1, 5, 7, 1, 1, 100, 1, 1, 9, 0, 1, 0,
              mk("sub_fwd", 1, 100, 7, 7, 4'b0001, 0, 3, 1, 0, 0, 1));
        issue(ADD, 1, 5, 7, 0, 0, 0, 1, 2, 33, 0, 1, 0,
              mk("fwd_b", 1, 5, 33, 33, 4'b0000, 0, 3, 1, 0, 0, 1));
        issue(ADD0, 1, 5, 7, 1, 0, 77, 0, 0, 0, 0, 1, 0,
              mk("x0_src", 1, 0, 7, 7, 4'b0000, 0, 3, 1, 0, 0, 1));
        issue(LUI, 1, 5, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              mk("lui", 1, 5, 32'h000ABCDE, 7, 4'b0110, 6, 4,
                 1, 0, 0, 1));
        issue(SRAI, 1, A, B, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              mk("srai", 1, A, 3, B, 4'b1010, 5, 1, 1, 0, 0, 1));
        issue(ADDI, 1, A, B, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              mk("addi_neg", 1, A, 32'hFFFFFFFF, B, 4'b0000, 0, 7,
                 1, 0, 0, 1));
        issue(SW, 1, A, B, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              mk("sw", 1, A, 8, B, 4'b0000, 2, 0, 0, 0, 1, 1));
        issue(BEQ, 1, A, B, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              mk("beq", 1, A, B, B, 4'b0010, 0, 0, 0, 0, 0, 1));
        id_pc = 32'h1000;
        issue(AUI, 1, A, B, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              mk("auipc", 1, 32'h1000, 32'h12345000, B, 4'b0000, 5,
                 9, 1, 0, 0, 1));
        issue(ADDX, 1, A, B, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              mk("rd_x0", 1, A, B, B, 4'b0000, 0, 0, 0, 0, 0, 1));
        issue(AND_, 1, A, B, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              mk("and", 1, A, B, B, 4'b0101, 7, 3, 1, 0, 0, 1));
        issue(32'h0000007F, 1, A, B, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              bub("unknown"));
        issue(ADD, 0, A, B, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              bub("novalid"));
        issue(32'h13, 1, A, B, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              bub("nop"));
        // load-use: one bubble, then the dependent add via fwd_a
        issue(LW, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              mk("lw", 1, 32'h200, 0, 0, 4'b0000, 2, 5, 1, 1, 0, 1));
        issue(ADD6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1,
              bub("lu_bubble"));
        issue(ADD6, 1, 1, 1, 1, 5, 32'h55, 0, 0, 0, 0, 1, 0,
              mk("lu_issue", 1, 32'h55, 32'h55, 32'h55, 4'b0000, 0, 6,
                 1, 0, 0, 1));
        // flush beats the load-use stall
        issue(LW, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              mk("lw2", 1, 32'h200, 0, 0, 4'b0000, 2, 5, 1, 1, 0, 1));
        issue(ADD6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0,
              bub("flush"));
        issue(ADD6, 1, 9, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              mk("post_flush", 1, 9, 9, 9, 4'b0000, 0, 6, 1, 0, 0, 1));
        chk("fsm_run", 32'(dut.state), 32'd0);
        // reset mid-stream with a pending load-use hazard
        issue(LW, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              mk("lw3", 1, 32'h200, 0, 0, 4'b0000, 2, 5, 1, 1, 0, 1));
        issue(ADD6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
              mk("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        issue(ADD6, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0,
              bub("after_rst"));
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clk);
        #2;
        chk("drain", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
